// File: rtl/prf_int_scb.sv
// Integer physical register file with a per-entry ready scoreboard and a post-reset clear sequencer.
// Define PRF_INT_SCB_RDREG_EN to register the read outputs (1-cycle read latency).
module prf_int_scb #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_ARCH  = 32,
  parameter  int XLEN      = 32,
  parameter  int NUM_RD    = 4,
  parameter  int NUM_WR    = 2,
  parameter  int NUM_ALLOC = 2,
  localparam int IDX_W     = $clog2(NUM_PREGS)
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       init_done,
  input  logic [NUM_RD*IDX_W-1:0]    rd_idx,
  output logic [NUM_RD*XLEN-1:0]     rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*IDX_W-1:0]    wr_idx,
  input  logic [NUM_WR*XLEN-1:0]     wr_data,
  input  logic [NUM_ALLOC-1:0]       alloc_en,
  input  logic [NUM_ALLOC*IDX_W-1:0] alloc_idx
);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     init_cnt;
  logic [XLEN-1:0]      mem [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready_q;

  logic [IDX_W-1:0]     rd_idx_a    [NUM_RD];
  logic [IDX_W-1:0]     wr_idx_a    [NUM_WR];
  logic [XLEN-1:0]      wr_data_a   [NUM_WR];
  logic [IDX_W-1:0]     alloc_idx_a [NUM_ALLOC];

  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]      rd_ready_c;

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) rd_idx_a[p] = rd_idx[p*IDX_W +: IDX_W];
    for (int w = 0; w < NUM_WR; w++) begin
      wr_idx_a[w]  = wr_idx[w*IDX_W +: IDX_W];
      wr_data_a[w] = wr_data[w*XLEN +: XLEN];
    end
    for (int a = 0; a < NUM_ALLOC; a++) alloc_idx_a[a] = alloc_idx[a*IDX_W +: IDX_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == IDX_W'(NUM_PREGS - 1)) state_nxt = RUN;
  end

  assign init_done = (state == RUN);

  // Data array is never reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clock) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_idx_a[w] != '0) mem[wr_idx_a[w]] <= wr_data_a[w];
    end
  end

  // Clears are applied after sets so an alloc beats a same-cycle writeback.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) ready_q[i] <= (i < NUM_ARCH);
    end else if (state == RUN) begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_idx_a[w] != '0) ready_q[wr_idx_a[w]] <= 1'b1;
      for (int a = 0; a < NUM_ALLOC; a++)
        if (alloc_en[a] && alloc_idx_a[a] != '0) ready_q[alloc_idx_a[a]] <= 1'b0;
    end
  end

  always_comb begin
    rd_data_c  = '0;
    rd_ready_c = '0;
    if (state == RUN) begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data_c[p*XLEN +: XLEN] = mem[rd_idx_a[p]];
        rd_ready_c[p]             = ready_q[rd_idx_a[p]];
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_idx_a[w] == rd_idx_a[p] && rd_idx_a[p] != '0) begin
            rd_data_c[p*XLEN +: XLEN] = wr_data_a[w];
            rd_ready_c[p]             = 1'b1;
          end
        end
        if (rd_idx_a[p] == '0) begin
          rd_data_c[p*XLEN +: XLEN] = '0;
          rd_ready_c[p]             = 1'b1;
        end
      end
    end
  end

`ifdef PRF_INT_SCB_RDREG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_ready <= '0;
    end else begin
      rd_data  <= rd_data_c;
      rd_ready <= rd_ready_c;
    end
  end
`else
  assign rd_data  = rd_data_c;
  assign rd_ready = rd_ready_c;
`endif

endmodule

// File: tb/tb_prf_int_scb.sv
// Scoreboard bench for prf_int_scb; follows PRF_INT_SCB_RDREG_EN for read latency.
module tb_prf_int_scb;

  localparam int NUM_PREGS = 64;
  localparam int NUM_ARCH  = 32;
  localparam int XLEN      = 32;
  localparam int NUM_RD    = 4;
  localparam int NUM_WR    = 2;
  localparam int NUM_ALLOC = 2;
  localparam int IDX_W     = 6;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic                       init_done;
  logic [NUM_RD*IDX_W-1:0]    rd_idx = '0;
  logic [NUM_RD*XLEN-1:0]     rd_data;
  logic [NUM_RD-1:0]          rd_ready;
  logic [NUM_WR-1:0]          wr_en = '0;
  logic [NUM_WR*IDX_W-1:0]    wr_idx = '0;
  logic [NUM_WR*XLEN-1:0]     wr_data = '0;
  logic [NUM_ALLOC-1:0]       alloc_en = '0;
  logic [NUM_ALLOC*IDX_W-1:0] alloc_idx = '0;

  int checks = 0;
  int passes = 0;

  logic [XLEN-1:0] sb_data  [$];
  logic            sb_ready [$];
  string           sb_name  [$];

  prf_int_scb #(
    .NUM_PREGS(NUM_PREGS), .NUM_ARCH(NUM_ARCH), .XLEN(XLEN),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)
  ) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one cycle of stimulus, queues the expected read result of every port,
  // and returns at the time that read result is visible.
  task automatic drive_step(input string nm,
                            input logic [1:0] we, input logic [5:0] wi1, wi0,
                            input logic [31:0] wd1, wd0,
                            input logic [1:0] ae, input logic [5:0] ai1, ai0,
                            input logic [5:0] r3, r2, r1, r0,
                            input logic [31:0] e3, e2, e1, e0,
                            input logic [3:0] er);
    wr_en     = we;
    wr_idx    = {wi1, wi0};
    wr_data   = {wd1, wd0};
    alloc_en  = ae;
    alloc_idx = {ai1, ai0};
    rd_idx    = {r3, r2, r1, r0};
    sb_data.push_back(e0); sb_data.push_back(e1); sb_data.push_back(e2); sb_data.push_back(e3);
    for (int p = 0; p < NUM_RD; p++) begin
      sb_ready.push_back(er[p]);
      sb_name.push_back(nm);
    end
`ifdef PRF_INT_SCB_RDREG_EN
    @(posedge clock);
    #2;
`else
    #2;
`endif
  endtask

  task automatic end_step();
`ifdef PRF_INT_SCB_RDREG_EN
    wr_en = '0; alloc_en = '0; rd_idx = '0; wr_idx = '0; wr_data = '0; alloc_idx = '0;
    @(posedge clock);
    #1;
`else
    @(posedge clock);
    #1;
    wr_en = '0; alloc_en = '0; rd_idx = '0; wr_idx = '0; wr_data = '0; alloc_idx = '0;
`endif
  endtask

  task automatic test_reset();
    checks++;
    #1;
    if (init_done !== 1'b0) $display("[TB] FAIL reset_init_done: got %b, expected 0", init_done);
    else passes++;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    rd_idx = {6'd0, 6'd0, 6'd0, 6'd5};
    for (int c = 1; c <= NUM_PREGS; c++) begin
      @(posedge clock);
      #1;
      if (c == 10) begin
        checks++;
        if (rd_data !== '0 || rd_ready !== 4'b0000)
          $display("[TB] FAIL init_reads_zero: got data=%h ready=%b, expected data=0 ready=0000", rd_data, rd_ready);
        else passes++;
      end
      if (c == NUM_PREGS - 1) begin
        checks++;
        if (init_done !== 1'b0) $display("[TB] FAIL init_done_early: got %b, expected 0 at cycle %0d", init_done, c);
        else passes++;
      end
      if (c == NUM_PREGS) begin
        checks++;
        if (init_done !== 1'b1) $display("[TB] FAIL init_done_rise: got %b, expected 1 at cycle %0d", init_done, c);
        else passes++;
      end
    end
    rd_idx = '0;
  endtask

  task automatic test_arch_ready();
    logic [31:0] ed; logic erb; string nm;
    drive_step("arch_ready", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
               6'd32, 6'd31, 6'd40, 6'd5, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0101);
    for (int p = 0; p < NUM_RD; p++) begin
      ed = sb_data.pop_front(); erb = sb_ready.pop_front(); nm = sb_name.pop_front();
      checks++;
      if (rd_data[p*XLEN +: XLEN] !== ed || rd_ready[p] !== erb)
        $display("[TB] FAIL %s port%0d: got data=%h ready=%b, expected data=%h ready=%b", nm, p, rd_data[p*XLEN +: XLEN], rd_ready[p], ed, erb);
      else passes++;
    end
    end_step();
  endtask

  task automatic test_alloc_write();
    logic [31:0] ed; logic erb; string nm;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: drive_step("aw_prewrite", 2'b01, 6'd0, 6'd40, 32'h0, 32'h55, 2'b00, 6'd0, 6'd0,
                      6'd0, 6'd0, 6'd0, 6'd40, 32'h0, 32'h0, 32'h0, 32'h55, 4'b1111);
        1: drive_step("aw_alloc_same_cycle", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b10, 6'd40, 6'd0,
                      6'd0, 6'd0, 6'd0, 6'd40, 32'h0, 32'h0, 32'h0, 32'h55, 4'b1111);
        2: drive_step("aw_after_alloc", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
                      6'd0, 6'd0, 6'd0, 6'd40, 32'h0, 32'h0, 32'h0, 32'h55, 4'b1110);
        3: drive_step("aw_bypass", 2'b01, 6'd0, 6'd40, 32'h0, 32'hDEADBEEF, 2'b00, 6'd0, 6'd0,
                      6'd0, 6'd0, 6'd40, 6'd40, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
        default: drive_step("aw_array", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
                      6'd0, 6'd0, 6'd40, 6'd0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 4'b1111);
      endcase
      for (int p = 0; p < NUM_RD; p++) begin
        ed = sb_data.pop_front(); erb = sb_ready.pop_front(); nm = sb_name.pop_front();
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_ready[p] !== erb)
          $display("[TB] FAIL %s port%0d: got data=%h ready=%b, expected data=%h ready=%b", nm, p, rd_data[p*XLEN +: XLEN], rd_ready[p], ed, erb);
        else passes++;
      end
      end_step();
    end
  endtask

  task automatic test_wr_priority();
    logic [31:0] ed; logic erb; string nm;
    for (int s = 0; s < 2; s++) begin
      if (s == 0)
        drive_step("prio_bypass", 2'b11, 6'd7, 6'd7, 32'h22, 32'h11, 2'b00, 6'd0, 6'd0,
                   6'd7, 6'd0, 6'd8, 6'd7, 32'h22, 32'h0, 32'h0, 32'h22, 4'b1111);
      else
        drive_step("prio_array", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
                   6'd0, 6'd7, 6'd0, 6'd0, 32'h0, 32'h22, 32'h0, 32'h0, 4'b1111);
      for (int p = 0; p < NUM_RD; p++) begin
        ed = sb_data.pop_front(); erb = sb_ready.pop_front(); nm = sb_name.pop_front();
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_ready[p] !== erb)
          $display("[TB] FAIL %s port%0d: got data=%h ready=%b, expected data=%h ready=%b", nm, p, rd_data[p*XLEN +: XLEN], rd_ready[p], ed, erb);
        else passes++;
      end
      end_step();
    end
  endtask

  task automatic test_preg0();
    logic [31:0] ed; logic erb; string nm;
    for (int s = 0; s < 2; s++) begin
      if (s == 0)
        drive_step("preg0_same_cycle", 2'b11, 6'd3, 6'd0, 32'h33, 32'hFFFFFFFF, 2'b01, 6'd0, 6'd0,
                   6'd0, 6'd0, 6'd3, 6'd0, 32'h0, 32'h0, 32'h33, 32'h0, 4'b1111);
      else
        drive_step("preg0_after", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
                   6'd0, 6'd0, 6'd3, 6'd0, 32'h0, 32'h0, 32'h33, 32'h0, 4'b1111);
      for (int p = 0; p < NUM_RD; p++) begin
        ed = sb_data.pop_front(); erb = sb_ready.pop_front(); nm = sb_name.pop_front();
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_ready[p] !== erb)
          $display("[TB] FAIL %s port%0d: got data=%h ready=%b, expected data=%h ready=%b", nm, p, rd_data[p*XLEN +: XLEN], rd_ready[p], ed, erb);
        else passes++;
      end
      end_step();
    end
  endtask

  task automatic test_alloc_wins();
    logic [31:0] ed; logic erb; string nm;
    for (int s = 0; s < 2; s++) begin
      if (s == 0)
        drive_step("aw50_bypass", 2'b10, 6'd50, 6'd0, 32'h1234, 32'h0, 2'b01, 6'd0, 6'd50,
                   6'd0, 6'd50, 6'd0, 6'd0, 32'h0, 32'h1234, 32'h0, 32'h0, 4'b1111);
      else
        drive_step("aw50_after", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
                   6'd0, 6'd50, 6'd0, 6'd0, 32'h0, 32'h1234, 32'h0, 32'h0, 4'b1011);
      for (int p = 0; p < NUM_RD; p++) begin
        ed = sb_data.pop_front(); erb = sb_ready.pop_front(); nm = sb_name.pop_front();
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_ready[p] !== erb)
          $display("[TB] FAIL %s port%0d: got data=%h ready=%b, expected data=%h ready=%b", nm, p, rd_data[p*XLEN +: XLEN], rd_ready[p], ed, erb);
        else passes++;
      end
      end_step();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] ed; logic erb; string nm;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive_step("mid_write9", 2'b10, 6'd9, 6'd0, 32'hAB, 32'h0, 2'b00, 6'd0, 6'd0,
                      6'd0, 6'd0, 6'd0, 6'd9, 32'h0, 32'h0, 32'h0, 32'hAB, 4'b1111);
        1: drive_step("mid_read9", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
                      6'd0, 6'd0, 6'd50, 6'd9, 32'h0, 32'h0, 32'h1234, 32'hAB, 4'b1101);
        default: drive_step("post_reset", 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 6'd0, 6'd0,
                      6'd32, 6'd40, 6'd50, 6'd9, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001);
      endcase
      for (int p = 0; p < NUM_RD; p++) begin
        ed = sb_data.pop_front(); erb = sb_ready.pop_front(); nm = sb_name.pop_front();
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_ready[p] !== erb)
          $display("[TB] FAIL %s port%0d: got data=%h ready=%b, expected data=%h ready=%b", nm, p, rd_data[p*XLEN +: XLEN], rd_ready[p], ed, erb);
        else passes++;
      end
      end_step();
      if (s == 1) begin
        rd_idx = {6'd0, 6'd0, 6'd0, 6'd9};
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (init_done !== 1'b0) $display("[TB] FAIL mid_reset_async: got init_done=%b, expected 0", init_done);
        else passes++;
        checks++;
        if (rd_ready !== 4'b0000) $display("[TB] FAIL mid_reset_ready: got %b, expected 0000", rd_ready);
        else passes++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 1; c <= NUM_PREGS; c++) begin
          @(posedge clock);
          #1;
          if (c == NUM_PREGS - 1) begin
            checks++;
            if (init_done !== 1'b0) $display("[TB] FAIL mid_init_done_early: got %b, expected 0", init_done);
            else passes++;
          end
          if (c == NUM_PREGS) begin
            checks++;
            if (init_done !== 1'b1) $display("[TB] FAIL mid_init_done_rise: got %b, expected 1", init_done);
            else passes++;
          end
        end
        rd_idx = '0;
      end
    end
  endtask

  initial begin
    $display("[TB] starting prf_int_scb bench");
    test_reset();
    test_arch_ready();
    test_alloc_write();
    test_wr_priority();
    test_preg0();
    test_alloc_wins();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
